// File: rtl/multi_timer_ctrl.sv
// N-channel countdown timer controller: per-channel time, preset and state, button-driven
// channel select and editing, 1 Hz countdown, and an alarm that times out back to the preset.
module multi_timer_ctrl #(
    parameter int  CHANNELS   = 4,
    parameter int  TW         = 13,
    parameter int  MAX_SEC    = 5999,
    parameter int  ALARM_SECS = 10,
    localparam int CW         = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sec,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_action,
    output logic [TW-1:0]       disp_time,
    output logic [1:0]          disp_state,
    output logic [CW-1:0]       disp_chan,
    output logic [CHANNELS-1:0] alarm
);

    localparam int AW = $clog2(ALARM_SECS + 1);

    localparam logic [TW-1:0] T_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [TW-1:0] T_MAX  = TW'(MAX_SEC);
    localparam logic [AW-1:0] A_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] A_ONE  = AW'(1);
    localparam logic [AW-1:0] A_INIT = AW'(ALARM_SECS);
    localparam logic [CW-1:0] S_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] S_ONE  = CW'(1);
    localparam logic [CW-1:0] S_LAST = CW'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_e;

    logic [4:0]    btn_s;
    logic [4:0]    btn_q;
    logic [4:0]    press_s;
    logic          up_p_s;
    logic          down_p_s;
    logic          left_p_s;
    logic          right_p_s;
    logic          act_p_s;

    logic [CW-1:0] sel_q;
    logic [CW-1:0] sel_d;

    logic [TW-1:0] time_q   [CHANNELS];
    logic [TW-1:0] time_d   [CHANNELS];
    logic [TW-1:0] preset_q [CHANNELS];
    logic [TW-1:0] preset_d [CHANNELS];
    state_e        state_q  [CHANNELS];
    state_e        state_d  [CHANNELS];
    logic [AW-1:0] acnt_q   [CHANNELS];
    logic [AW-1:0] acnt_d   [CHANNELS];

    logic [CHANNELS-1:0] alarm_s;
    logic [TW-1:0]       disp_time_q;
    logic [1:0]          disp_state_q;
    logic [CW-1:0]       disp_chan_q;
    logic [CHANNELS-1:0] alarm_q;

    // History resets to all-ones so a button held through reset never registers a press.
    assign btn_s     = {btn_action, btn_right, btn_left, btn_down, btn_up};
    assign press_s   = btn_s & ~btn_q;
    assign up_p_s    = press_s[0];
    assign down_p_s  = press_s[1];
    assign left_p_s  = press_s[2];
    assign right_p_s = press_s[3];
    assign act_p_s   = press_s[4];

    // Button level history for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 5'b11111;
        end else begin
            btn_q <= btn_s;
        end
    end

    // Next selected channel, wrapping in both directions
    always_comb begin
        sel_d = sel_q;
        if (right_p_s && !left_p_s) begin
            sel_d = (sel_q == S_LAST) ? S_ZERO : sel_q + S_ONE;
        end else if (left_p_s && !right_p_s) begin
            sel_d = (sel_q == S_ZERO) ? S_LAST : sel_q - S_ONE;
        end else begin
            sel_d = sel_q;
        end
    end

    // Per-channel next state: an action on the selected channel swallows that channel's tick
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            time_d[i]   = time_q[i];
            preset_d[i] = preset_q[i];
            state_d[i]  = state_q[i];
            acnt_d[i]   = acnt_q[i];

            if ((sel_q == CW'(i)) && act_p_s) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (time_q[i] != T_ZERO) begin
                            state_d[i]  = ST_RUN;
                            preset_d[i] = time_q[i];
                        end else begin
                            state_d[i]  = ST_IDLE;
                        end
                    end
                    ST_RUN:   state_d[i] = ST_PAUSE;
                    ST_PAUSE: begin
                        if (time_q[i] != T_ZERO) begin
                            state_d[i] = ST_RUN;
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end
                    ST_ALARM: begin
                        state_d[i] = ST_IDLE;
                        time_d[i]  = preset_q[i];
                        acnt_d[i]  = A_ZERO;
                    end
                    default:  state_d[i] = ST_IDLE;
                endcase
            end else begin
                if ((sel_q == CW'(i)) && (up_p_s != down_p_s) &&
                    ((state_q[i] == ST_IDLE) || (state_q[i] == ST_PAUSE))) begin
                    if (up_p_s) begin
                        time_d[i] = (time_q[i] < T_MAX) ? time_q[i] + T_ONE : T_MAX;
                    end else begin
                        time_d[i] = (time_q[i] != T_ZERO) ? time_q[i] - T_ONE : T_ZERO;
                    end
                end else begin
                    time_d[i] = time_q[i];
                end

                if (sec) begin
                    case (state_q[i])
                        ST_RUN: begin
                            if (time_q[i] > T_ONE) begin
                                time_d[i] = time_q[i] - T_ONE;
                            end else begin
                                time_d[i]  = T_ZERO;
                                state_d[i] = ST_ALARM;
                                acnt_d[i]  = A_INIT;
                            end
                        end
                        ST_ALARM: begin
                            if (acnt_q[i] > A_ONE) begin
                                acnt_d[i] = acnt_q[i] - A_ONE;
                            end else begin
                                acnt_d[i]  = A_ZERO;
                                state_d[i] = ST_IDLE;
                                time_d[i]  = preset_q[i];
                            end
                        end
                        default: state_d[i] = state_q[i];
                    endcase
                end else begin
                    acnt_d[i] = acnt_q[i];
                end
            end
        end
    end

    // Channel state and selection registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= S_ZERO;
            for (int i = 0; i < CHANNELS; i++) begin
                time_q[i]   <= T_ZERO;
                preset_q[i] <= T_ZERO;
                state_q[i]  <= ST_IDLE;
                acnt_q[i]   <= A_ZERO;
            end
        end else begin
            sel_q <= sel_d;
            for (int i = 0; i < CHANNELS; i++) begin
                time_q[i]   <= time_d[i];
                preset_q[i] <= preset_d[i];
                state_q[i]  <= state_d[i];
                acnt_q[i]   <= acnt_d[i];
            end
        end
    end

    // Per-channel alarm flags
    always_comb begin
        alarm_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            alarm_s[i] = (state_q[i] == ST_ALARM);
        end
    end

    // Registered display outputs, one cycle behind the internal state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_time_q  <= T_ZERO;
            disp_state_q <= 2'd0;
            disp_chan_q  <= S_ZERO;
            alarm_q      <= {CHANNELS{1'b0}};
        end else begin
            disp_time_q  <= time_q[sel_q];
            disp_state_q <= state_q[sel_q];
            disp_chan_q  <= sel_q;
            alarm_q      <= alarm_s;
        end
    end

    assign disp_time  = disp_time_q;
    assign disp_state = disp_state_q;
    assign disp_chan  = disp_chan_q;
    assign alarm      = alarm_q;

endmodule

// File: tb/tb_multi_timer_ctrl.sv
// Self-checking bench for multi_timer_ctrl: directed scenarios plus random button/tick traffic
// compared against a channel-level behavioural model.
module tb_multi_timer_ctrl;

    localparam int NCH   = 4;
    localparam int MAXS  = 5999;
    localparam int ASECS = 10;

    logic        clk;
    logic        rst_n;
    logic        sec;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_action;
    logic [12:0] disp_time;
    logic [1:0]  disp_state;
    logic [1:0]  disp_chan;
    logic [3:0]  alarm;

    int n_checks;
    int n_fail;

    // Model: state codes 0 IDLE, 1 RUN, 2 PAUSE, 3 ALARM
    int m_time   [NCH];
    int m_preset [NCH];
    int m_state  [NCH];
    int m_left_s [NCH];
    int m_sel;
    bit p_up, p_dn, p_l, p_r, p_a;
    int e_time, e_state, e_chan;
    logic [3:0] e_alarm;

    multi_timer_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sec        (sec),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_action (btn_action),
        .disp_time  (disp_time),
        .disp_state (disp_state),
        .disp_chan  (disp_chan),
        .alarm      (alarm)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_time[c] = 0; m_preset[c] = 0; m_state[c] = 0; m_left_s[c] = 0;
        end
        m_sel = 0;
        p_up = 1'b1; p_dn = 1'b1; p_l = 1'b1; p_r = 1'b1; p_a = 1'b1;
        e_time = 0; e_state = 0; e_chan = 0; e_alarm = 4'b0000;
    endtask

    task automatic model_step();
        bit pu, pd, pl, pr, pa;
        e_time  = m_time[m_sel];
        e_state = m_state[m_sel];
        e_chan  = m_sel;
        for (int c = 0; c < NCH; c++) e_alarm[c] = (m_state[c] == 3);
        pu = btn_up && !p_up;     pd = btn_down && !p_dn;
        pl = btn_left && !p_l;    pr = btn_right && !p_r;
        pa = btn_action && !p_a;
        p_up = btn_up; p_dn = btn_down; p_l = btn_left; p_r = btn_right; p_a = btn_action;
        for (int c = 0; c < NCH; c++) begin
            if (c == m_sel && pa) begin
                if (m_state[c] == 0 && m_time[c] != 0) begin
                    m_state[c] = 1; m_preset[c] = m_time[c];
                end else if (m_state[c] == 1) begin
                    m_state[c] = 2;
                end else if (m_state[c] == 2) begin
                    m_state[c] = (m_time[c] != 0) ? 1 : 0;
                end else if (m_state[c] == 3) begin
                    m_state[c] = 0; m_time[c] = m_preset[c]; m_left_s[c] = 0;
                end
            end else begin
                if (c == m_sel && (m_state[c] == 0 || m_state[c] == 2) && (pu != pd)) begin
                    if (pu) m_time[c] = (m_time[c] + 1 > MAXS) ? MAXS : m_time[c] + 1;
                    else    m_time[c] = (m_time[c] - 1 < 0) ? 0 : m_time[c] - 1;
                end
                if (sec && m_state[c] == 1) begin
                    m_time[c] = m_time[c] - 1;
                    if (m_time[c] == 0) begin
                        m_state[c] = 3; m_left_s[c] = ASECS;
                    end
                end else if (sec && m_state[c] == 3) begin
                    m_left_s[c] = m_left_s[c] - 1;
                    if (m_left_s[c] == 0) begin
                        m_state[c] = 0; m_time[c] = m_preset[c];
                    end
                end
            end
        end
        if (pr && !pl)      m_sel = (m_sel + 1) % NCH;
        else if (pl && !pr) m_sel = (m_sel + NCH - 1) % NCH;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic press(input int b);
        case (b)
            0: btn_up = 1'b1;
            1: btn_down = 1'b1;
            2: btn_left = 1'b1;
            3: btn_right = 1'b1;
            default: btn_action = 1'b1;
        endcase
        cyc();
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_action = 1'b0;
        cyc();
    endtask

    task automatic tick();
        sec = 1'b1;
        cyc();
        sec = 1'b0;
        cyc();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        sec = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        btn_action = 1'b0;
        #3;
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({disp_time, disp_state, disp_chan, alarm} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got time=%0d state=%0d chan=%0d alarm=%b want all 0",
                     disp_time, disp_state, disp_chan, alarm);
        end
        apply_reset();
        cyc();
        n_checks++;
        if ({disp_time, disp_state, disp_chan, alarm} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_after_release: got time=%0d state=%0d chan=%0d alarm=%b want all 0",
                     disp_time, disp_state, disp_chan, alarm);
        end
    endtask

    task automatic test_countdown();
        repeat (5) press(0);
        press(4);
        n_checks++;
        if (disp_time !== 13'd5 || disp_state !== 2'd1) begin
            n_fail++;
            $display("FAIL start_ch0: got time=%0d state=%0d want 5/1", disp_time, disp_state);
        end
        repeat (4) tick();
        n_checks++;
        if (disp_time !== 13'd1 || disp_state !== 2'd1) begin
            n_fail++;
            $display("FAIL count_4_ticks: got time=%0d state=%0d want 1/1", disp_time, disp_state);
        end
        tick();
        n_checks++;
        if (disp_time !== 13'd0 || disp_state !== 2'd3 || alarm !== 4'b0001) begin
            n_fail++;
            $display("FAIL expire_ch0: got time=%0d state=%0d alarm=%b want 0/3/0001",
                     disp_time, disp_state, alarm);
        end
    endtask

    task automatic test_alarm_timeout();
        repeat (ASECS - 1) tick();
        n_checks++;
        if (disp_state !== 2'd3 || alarm !== 4'b0001) begin
            n_fail++;
            $display("FAIL alarm_held_9: got state=%0d alarm=%b want 3/0001", disp_state, alarm);
        end
        tick();
        n_checks++;
        if (disp_time !== 13'd5 || disp_state !== 2'd0 || alarm !== 4'b0000) begin
            n_fail++;
            $display("FAIL alarm_timeout: got time=%0d state=%0d alarm=%b want 5/0/0000",
                     disp_time, disp_state, alarm);
        end
    endtask

    task automatic test_saturation();
        repeat (6) press(1);
        n_checks++;
        if (disp_time !== 13'd0) begin
            n_fail++;
            $display("FAIL down_floor: got %0d want 0", disp_time);
        end
        for (int k = 0; k < MAXS; k++) press(0);
        n_checks++;
        if (disp_time !== 13'd5999) begin
            n_fail++;
            $display("FAIL up_to_max: got %0d want 5999", disp_time);
        end
        press(0);
        n_checks++;
        if (disp_time !== 13'd5999) begin
            n_fail++;
            $display("FAIL up_ceiling: got %0d want 5999", disp_time);
        end
        btn_up = 1'b1; btn_down = 1'b1;
        cyc();
        btn_up = 1'b0; btn_down = 1'b0;
        cyc();
        n_checks++;
        if (disp_time !== 13'd5999) begin
            n_fail++;
            $display("FAIL up_down_same: got %0d want 5999", disp_time);
        end
        press(1);
        n_checks++;
        if (disp_time !== 13'd5998) begin
            n_fail++;
            $display("FAIL down_from_max: got %0d want 5998", disp_time);
        end
    endtask

    task automatic test_multi_channel();
        apply_reset();
        repeat (3) press(0);
        press(4);
        press(3);
        repeat (2) press(0);
        press(4);
        n_checks++;
        if (disp_chan !== 2'd1 || disp_state !== 2'd1 || disp_time !== 13'd2) begin
            n_fail++;
            $display("FAIL ch1_start: got chan=%0d state=%0d time=%0d want 1/1/2",
                     disp_chan, disp_state, disp_time);
        end
        repeat (2) tick();
        n_checks++;
        if (disp_state !== 2'd3 || disp_time !== 13'd0 || alarm !== 4'b0010) begin
            n_fail++;
            $display("FAIL ch1_alarm: got state=%0d time=%0d alarm=%b want 3/0/0010",
                     disp_state, disp_time, alarm);
        end
        press(2);
        n_checks++;
        if (disp_chan !== 2'd0 || disp_time !== 13'd1 || disp_state !== 2'd1) begin
            n_fail++;
            $display("FAIL ch0_running: got chan=%0d time=%0d state=%0d want 0/1/1",
                     disp_chan, disp_time, disp_state);
        end
    endtask

    task automatic test_action_with_tick();
        apply_reset();
        press(3); press(3);
        repeat (3) press(0);
        press(4);
        press(2); press(2);
        repeat (4) press(0);
        press(4);
        btn_action = 1'b1; sec = 1'b1;
        cyc();
        btn_action = 1'b0; sec = 1'b0;
        cyc();
        n_checks++;
        if (disp_state !== 2'd2 || disp_time !== 13'd4) begin
            n_fail++;
            $display("FAIL action_beats_tick: got state=%0d time=%0d want 2/4", disp_state, disp_time);
        end
        press(3); press(3);
        n_checks++;
        if (disp_chan !== 2'd2 || disp_time !== 13'd2 || disp_state !== 2'd1) begin
            n_fail++;
            $display("FAIL other_chan_ticks: got chan=%0d time=%0d state=%0d want 2/2/1",
                     disp_chan, disp_time, disp_state);
        end
    endtask

    task automatic test_select_wrap();
        apply_reset();
        press(2);
        n_checks++;
        if (disp_chan !== 2'd3) begin
            n_fail++;
            $display("FAIL left_wrap: got %0d want 3", disp_chan);
        end
        press(3);
        n_checks++;
        if (disp_chan !== 2'd0) begin
            n_fail++;
            $display("FAIL right_wrap: got %0d want 0", disp_chan);
        end
        btn_left = 1'b1; btn_right = 1'b1;
        cyc();
        btn_left = 1'b0; btn_right = 1'b0;
        cyc();
        n_checks++;
        if (disp_chan !== 2'd0) begin
            n_fail++;
            $display("FAIL left_right_same: got %0d want 0", disp_chan);
        end
    endtask

    task automatic test_reset_in_alarm();
        apply_reset();
        press(0);
        press(4);
        tick();
        n_checks++;
        if (disp_state !== 2'd3 || alarm !== 4'b0001) begin
            n_fail++;
            $display("FAIL pre_reset_alarm: got state=%0d alarm=%b want 3/0001", disp_state, alarm);
        end
        #4;
        rst_n = 1'b0;
        btn_up = 1'b1; btn_right = 1'b1; btn_action = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({disp_time, disp_state, disp_chan, alarm} !== 21'd0) begin
            n_fail++;
            $display("FAIL async_reset: got time=%0d state=%0d chan=%0d alarm=%b want all 0",
                     disp_time, disp_state, disp_chan, alarm);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc();
        n_checks++;
        if ({disp_time, disp_state, disp_chan, alarm} !== 21'd0) begin
            n_fail++;
            $display("FAIL held_buttons_release: got time=%0d state=%0d chan=%0d alarm=%b want all 0",
                     disp_time, disp_state, disp_chan, alarm);
        end
        btn_up = 1'b0; btn_right = 1'b0; btn_action = 1'b0;
        cyc();
        press(0);
        n_checks++;
        if (disp_time !== 13'd1 || disp_chan !== 2'd0) begin
            n_fail++;
            $display("FAIL press_after_release: got time=%0d chan=%0d want 1/0", disp_time, disp_chan);
        end
    endtask

    task automatic test_random();
        bit nu, nd, nl, nr, na;
        apply_reset();
        for (int k = 0; k < 4000; k++) begin
            nu = ($urandom_range(0, 3) == 0) ? !btn_up : btn_up;
            nd = ($urandom_range(0, 5) == 0) ? !btn_down : btn_down;
            nl = ($urandom_range(0, 9) == 0) ? !btn_left : btn_left;
            nr = ($urandom_range(0, 9) == 0) ? !btn_right : btn_right;
            na = ($urandom_range(0, 7) == 0) ? !btn_action : btn_action;
            if (na && !btn_action && ((nu && !btn_up) || (nd && !btn_down))) na = btn_action;
            btn_up = nu; btn_down = nd; btn_left = nl; btn_right = nr; btn_action = na;
            sec = ($urandom_range(0, 3) == 0);
            cyc();
            n_checks++;
            if (disp_time !== 13'(e_time) || disp_state !== 2'(e_state) ||
                disp_chan !== 2'(e_chan) || alarm !== e_alarm) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got time=%0d state=%0d chan=%0d alarm=%b want %0d/%0d/%0d/%b",
                         k, disp_time, disp_state, disp_chan, alarm, e_time, e_state, e_chan, e_alarm);
            end
        end
        sec = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        btn_action = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        model_reset();
        test_reset();
        test_countdown();
        test_alarm_timeout();
        test_saturation();
        test_multi_channel();
        test_action_with_tick();
        test_select_wrap();
        test_reset_in_alarm();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
